// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - two-stage RV32I OP/OP-IMM execute stage with valid/ready handshake

// Combinational RV32I base alu, selected by funct3 (no SUB/SRA)
module alu (
    input  logic [2:0]  inst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rslt
);

    // funct3 decode; shifts use b[4:0] only
    always_comb begin
        rslt = 32'd0;
        case (inst)
            3'b000:  rslt = a + b;
            3'b001:  rslt = a << b[4:0];
            3'b010:  rslt = {31'd0, $signed(a) < $signed(b)};
            3'b011:  rslt = {31'd0, a < b};
            3'b100:  rslt = a ^ b;
            3'b101:  rslt = a >> b[4:0];
            3'b110:  rslt = a | b;
            default: rslt = a & b;
        endcase
    end

endmodule

module alu_ex_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_alt,
    input  logic             in_is_imm,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [31:0]      in_imm,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_rslt,
    output logic [TAG_W-1:0] out_rd
);

    logic             s1_valid;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [2:0]       s1_f3;
    logic [TAG_W-1:0] s1_rd;
    logic             s1_is_sub;
    logic             s1_is_sra;

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;
    logic [31:0]      alu_b;
    logic [31:0]      alu_rslt;
    logic [31:0]      ex_rslt;

    // S2 can take a new op when empty or draining this cycle; the chain reaches in_ready
    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !rst && !flush && (!s1_valid || s2_free);
    assign in_fire  = in_valid && in_ready;

    // SUB is realised as a + (-b); 0x8000_0000 negates to itself under 32-bit wrap
    assign alu_b = s1_is_sub ? (~s1_b + 32'd1) : s1_b;

    alu u_alu (
        .inst (s1_f3),
        .a    (s1_a),
        .b    (alu_b),
        .rslt (alu_rslt)
    );

    // SRA = SRL with the vacated upper bits refilled from the sign of a
    always_comb begin
        ex_rslt = alu_rslt;
        if (s1_is_sra && s1_a[31]) begin
            ex_rslt = alu_rslt | ~(32'hFFFF_FFFF >> s1_b[4:0]);
        end
    end

    // S1 operand register: capture on accept, empty when advanced without refill
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= 32'd0;
            s1_b      <= 32'd0;
            s1_f3     <= 3'd0;
            s1_rd     <= '0;
            s1_is_sub <= 1'b0;
            s1_is_sra <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid  <= 1'b1;
            s1_a      <= in_rs1;
            s1_b      <= in_is_imm ? in_imm : in_rs2;
            s1_f3     <= in_funct3;
            s1_rd     <= in_rd;
            s1_is_sub <= (in_funct3 == 3'b000) && in_alt && !in_is_imm;
            s1_is_sra <= (in_funct3 == 3'b101) && in_alt;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 result register: load on advance, hold under backpressure, clear when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rslt  <= 32'd0;
            out_rd    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_rslt  <= ex_rslt;
            out_rd    <= s1_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - directed self-checking bench for alu_ex_stage

module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic        in_is_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rslt;
    logic [4:0]  out_rd;

    int n_cmp = 0;
    int n_mis = 0;

    int          sent;
    int          got;
    int          stall;
    int          cyc;
    bit          seen;
    logic [31:0] held;

    alu_ex_stage #(.TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_is_imm (in_is_imm),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rslt  (out_rslt),
        .out_rd    (out_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] f3, input logic alt, input logic imm_sel,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [4:0] rd);
        in_funct3 = f3;
        in_alt    = alt;
        in_is_imm = imm_sel;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_rd     = rd;
    endtask

    // one op through an idle pipe with out_ready high: accept, then result two edges later
    task automatic do_op(input string tag, input logic [2:0] f3, input logic alt,
                         input logic imm_sel, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] exp);
        @(negedge clk);
        set_op(f3, alt, imm_sel, rs1, rs2, imm, rd);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({tag, "/early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "/valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "/rslt"}, out_rslt, exp);
        chk({tag, "/rd"}, {27'd0, out_rd}, {27'd0, rd});
    endtask

    // fill both stages with out_ready low: A in S2, B in S1
    task automatic fill_both;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd1);
        @(negedge clk);
        set_op(3'b000, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0, 5'd2);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full/out_valid", {31'd0, out_valid}, 32'd1);
        chk("full/in_ready", {31'd0, in_ready}, 32'd0);
        set_op(3'b000, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0, 5'd7);
        in_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_op(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst/out_rslt", out_rslt, 32'd0);
        chk("rst/out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst/in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1 chk("rst_release/in_ready", {31'd0, in_ready}, 32'd1);

        // arithmetic, shifts, compares, logic
        do_op("add",     3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 32'd12);
        do_op("sub",     3'b000, 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFE);
        do_op("addi_alt",3'b000, 1'b1, 1'b1, 32'd3, 32'h100, 32'd5, 5'd5, 32'd8);
        do_op("sub_min", 3'b000, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'd0, 5'd6, 32'h8000_0000);
        do_op("sra",     3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd7, 32'hF800_0000);
        do_op("srl",     3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd8, 32'h0800_0000);
        do_op("sra_0",   3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 5'd9, 32'h8000_0000);
        do_op("sra_36",  3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd36, 32'd0, 5'd10, 32'hF800_0000);
        do_op("srai",    3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 32'h404, 5'd11, 32'hF800_0000);
        do_op("sll",     3'b001, 1'b0, 1'b0, 32'd1, 32'd31, 32'd0, 5'd12, 32'h8000_0000);
        do_op("slt",     3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd13, 32'd1);
        do_op("sltu",    3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd14, 32'd0);
        do_op("xor",     3'b100, 1'b1, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 5'd15, 32'h0FF0);
        do_op("or",      3'b110, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 5'd16, 32'hFFF0);
        do_op("and",     3'b111, 1'b0, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 5'd17, 32'hF000);

        // backpressure: 4 back-to-back ADDs, out_ready low 3 cycles after first out_valid
        sent = 0; got = 0; stall = 0; cyc = 0; seen = 1'b0; held = 32'd0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !seen) begin
                seen  = 1'b1;
                stall = 3;
                held  = out_rslt;
            end
            out_ready = (stall == 0);
            in_valid  = (sent < 4);
            set_op(3'b000, 1'b0, 1'b0, 32'(sent * 16), 32'd1, 32'd0, 5'(sent + 8));
            #1;
            if (stall > 0) begin
                chk("bp/in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp/hold", out_rslt, held);
                stall--;
            end else if (out_valid) begin
                chk("bp/rslt", out_rslt, 32'(got * 16 + 1));
                chk("bp/rd", {27'd0, out_rd}, 32'(got + 8));
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        chk("bp/count", 32'(got), 32'd4);
        @(negedge clk);
        #1 chk("bp/no_dup", {31'd0, out_valid}, 32'd0);

        // flush with both stages full
        fill_both();
        flush = 1'b1;
        #1 chk("flush/in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 chk("flush/out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1 chk("flush/no_stale", {31'd0, out_valid}, 32'd0);
        end
        do_op("post_flush", 3'b000, 1'b0, 1'b0, 32'd20, 32'd22, 32'd0, 5'd21, 32'd42);

        // reset with both stages full
        fill_both();
        rst = 1'b1;
        #1 chk("rst_mid/in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_mid/out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid/out_rslt", out_rslt, 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1 chk("rst_mid/no_stale", {31'd0, out_valid}, 32'd0);
        end
        do_op("post_rst", 3'b000, 1'b1, 1'b0, 32'd100, 32'd1, 32'd0, 5'd30, 32'd99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
